key_conditioner: RTL and testbench

Input conditioning stage that sits directly upstream of the keypad combination-lock state machine and drives its `keys` input. It synchronises raw asynchronous push-button levels into the `clk` domain and debounces each button independently. It converts each debounced press into a single-cycle pulse, so the lock sees exactly one event per physical press. An optional collision filter rejects presses made while another key is held.

---
 rtl/key_conditioner.sv | 104 ++++++++++
 tb/tb_key_conditioner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: per-key two-flop synchroniser, debounce counter and one-cycle press pulse.
// Optional collision filter is compiled in by defining KEY_CONDITIONER_COLLISION_EN.
module key_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] keys_raw,
  output logic [WIDTH-1:0] keys,
  output logic [WIDTH-1:0] held,
  output logic             collision
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1_p0;
  logic [WIDTH-1:0] r_sync2_p1;
  logic [WIDTH-1:0] r_held_p2;
  logic [CNT_W-1:0] r_cnt_p2 [WIDTH];
  logic [WIDTH-1:0] r_keys_p3;
  logic             r_collision_p3;

  logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_held_nxt;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_keys_nxt;
  logic             w_collision_nxt;

  // Stage p0/p1: two-flop synchroniser for the asynchronous button levels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1_p0 <= '0;
      r_sync2_p1 <= '0;
    end else begin
      r_sync1_p0 <= keys_raw;
      r_sync2_p1 <= r_sync1_p0;
    end
  end

  // Stage p2: debounce; any return to the held level restarts the count
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_held_nxt[i] = r_held_p2[i];
      w_cnt_nxt[i]  = '0;
      if (r_sync2_p1[i] != r_held_p2[i]) begin
        if (r_cnt_p2[i] == CNT_LAST) begin
          w_held_nxt[i] = ~r_held_p2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt_p2[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_held_p2 <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt_p2[i] <= '0;
      end
    end else begin
      r_held_p2 <= w_held_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt_p2[i] <= w_cnt_nxt[i];
      end
    end
  end

  // Stage p3: press pulse registered on the same edge that raises held
  assign w_rise = w_held_nxt & ~r_held_p2;

`ifdef KEY_CONDITIONER_COLLISION_EN
  logic [WIDTH-1:0] w_others;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_others[i] = |(w_held_nxt & ~(WIDTH'(1) << i));
    end
  end

  assign w_keys_nxt      = w_rise & ~w_others;
  assign w_collision_nxt = |(w_rise & w_others);
`else
  assign w_keys_nxt      = w_rise;
  assign w_collision_nxt = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_keys_p3      <= '0;
      r_collision_p3 <= 1'b0;
    end else begin
      r_keys_p3      <= w_keys_nxt;
      r_collision_p3 <= w_collision_nxt;
    end
  end

  assign keys      = r_keys_p3;
  assign held      = r_held_p2;
  assign collision = r_collision_p3;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: stimulus queues expected pulses, a monitor checks them.
module tb_key_conditioner;

  localparam int W   = 4;
  localparam int D   = 4;
  localparam int LAT = D + 2;  // negedge drive at cycle N -> pulse seen at cycle N+LAT

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] keys_raw = '0;
  logic [W-1:0] keys;
  logic [W-1:0] held;
  logic         collision;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  typedef struct {
    int unsigned  cyc;
    logic [W-1:0] keys;
    logic         coll;
  } exp_t;

  exp_t q[$];

  key_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .keys_raw (keys_raw),
    .keys     (keys),
    .held     (held),
    .collision(collision)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [W-1:0] k, input logic c);
    exp_t e;
    e.cyc  = cyc + LAT;
    e.keys = k;
    e.coll = c;
    q.push_back(e);
  endtask

  // Monitor: every visible pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (reset && (keys !== '0 || collision !== 1'b0)) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: keys=%b collision=%b with nothing expected (cycle %0d)",
                 keys, collision, cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_keys", 32'(keys), 32'(e.keys));
        chk("pulse_collision", 32'(collision), 32'(e.coll));
      end
    end
  end

  initial begin
    // Reset held low for three cycles with every key pressed
    keys_raw = 4'b1111;
    reset    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_keys", 32'(keys), 0);
      chk("rst_held", 32'(held), 0);
      chk("rst_collision", 32'(collision), 0);
    end
    reset = 1'b1;
`ifdef KEY_CONDITIONER_COLLISION_EN
    push_exp(4'b0000, 1'b1);
`else
    push_exp(4'b1111, 1'b0);
`endif
    wait_n(LAT - 1);
    chk("rst_held_before_edge5", 32'(held), 0);
    wait_n(1);
    chk("rst_held_at_edge5", 32'(held), 32'hF);
    keys_raw = '0;
    wait_n(LAT - 1);
    chk("release_held_before_edge5", 32'(held), 32'hF);
    wait_n(1);
    chk("release_held_at_edge5", 32'(held), 0);
    wait_n(4);

    // Clean press of key 2 held for 20 cycles
    keys_raw = 4'b0100;
    push_exp(4'b0100, 1'b0);
    wait_n(20);
    chk("clean_held", 32'(held), 32'h4);
    keys_raw = '0;
    wait_n(10);
    chk("clean_release_held", 32'(held), 0);

    // Bounce on key 0: 1,0,1,0 then stable 1
    keys_raw = 4'b0001; wait_n(1);
    keys_raw = 4'b0000; wait_n(1);
    keys_raw = 4'b0001; wait_n(1);
    keys_raw = 4'b0000; wait_n(1);
    keys_raw = 4'b0001;
    push_exp(4'b0001, 1'b0);
    wait_n(12);
    chk("bounce_held", 32'(held), 32'h1);
    keys_raw = '0;
    wait_n(10);

    // Glitch of D-1 raw cycles never reaches held
    keys_raw = 4'b1000;
    wait_n(D - 1);
    keys_raw = '0;
    wait_n(3);
    chk("glitch_held_mid", 32'(held), 0);
    wait_n(7);
    chk("glitch_held_end", 32'(held), 0);

    // Release and re-press key 1: two pulses, none on release
    keys_raw = 4'b0010;
    push_exp(4'b0010, 1'b0);
    wait_n(12);
    keys_raw = '0;
    wait_n(10);
    chk("repress_released_held", 32'(held), 0);
    keys_raw = 4'b0010;
    push_exp(4'b0010, 1'b0);
    wait_n(12);
    chk("repress_held", 32'(held), 32'h2);
    keys_raw = '0;
    wait_n(10);

`ifdef KEY_CONDITIONER_COLLISION_EN
    // Key 0 pressed while key 3 held is rejected; alone it passes
    keys_raw = 4'b1000;
    push_exp(4'b1000, 1'b0);
    wait_n(12);
    keys_raw = 4'b1001;
    push_exp(4'b0000, 1'b1);
    wait_n(12);
    chk("coll_held", 32'(held), 32'h9);
    keys_raw = '0;
    wait_n(12);
    keys_raw = 4'b0001;
    push_exp(4'b0001, 1'b0);
    wait_n(12);
    keys_raw = '0;
    wait_n(12);
`endif

    // Asynchronous reset between edges while key 2 count is at 2
    keys_raw = 4'b1000;
    push_exp(4'b1000, 1'b0);
    wait_n(12);
    chk("arst_pre_held", 32'(held), 32'h8);
    keys_raw = 4'b1100;
    wait_n(4);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_held_immediate", 32'(held), 0);
    chk("arst_keys_immediate", 32'(keys), 0);
    chk("arst_collision_immediate", 32'(collision), 0);
    wait_n(2);
    chk("arst_held_during", 32'(held), 0);
    reset = 1'b1;
`ifdef KEY_CONDITIONER_COLLISION_EN
    push_exp(4'b0000, 1'b1);
`else
    push_exp(4'b1100, 1'b0);
`endif
    wait_n(LAT - 1);
    chk("arst_rearm_held_before", 32'(held), 0);
    wait_n(1);
    chk("arst_rearm_held", 32'(held), 32'hC);
    keys_raw = '0;
    wait_n(12);

    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
